// File: rtl/imm_ext_pkg.sv
// Shared types and default widths for the immediate-extension pipeline.
package imm_ext_pkg;

    localparam int IMM_IN_W  = 16;
    localparam int IMM_OUT_W = 32;

    typedef enum logic [1:0] {
        SIGN   = 2'd0,
        ZERO   = 2'd1,
        UPPER  = 2'd2,
        BRANCH = 2'd3
    } ext_mode_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ext_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign, zero, upper (LUI) and branch-offset modes.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = IMM_IN_W,
    parameter int OUT_W    = IMM_OUT_W,
    parameter int BR_SHIFT = 2
) (
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic [OUT_W-1:0] result
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;

    assign sext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};

    always_comb begin
        result = sext;
        case (ext_mode_t'(in_mode))
            SIGN:    result = sext;
            ZERO:    result = {{PAD_W{1'b0}}, in_imm};
            UPPER:   result = {in_imm, {PAD_W{1'b0}}};
            // Bits shifted past OUT_W-1 are simply dropped.
            BRANCH:  result = sext << BR_SHIFT;
            default: result = sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready handshake and 2-entry skid buffer.
// Define IMM_EXTEND_STATS_EN to add the ext_count transfer counter port.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = IMM_IN_W,
    parameter int OUT_W    = IMM_OUT_W,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef IMM_EXTEND_STATS_EN
    ,
    output logic [31:0]      ext_count
`endif
);

    ext_state_t       state, state_n;
    logic [OUT_W-1:0] ext_res;
    logic [OUT_W-1:0] skid_q;
    logic             in_fire, out_fire;
    logic             load_main, load_skid, skid_to_main;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    imm_ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .in_imm  (in_imm),
        .in_mode (in_mode),
        .result  (ext_res)
    );

    always_comb begin
        state_n      = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_n   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_n   = FULL;
                end else if (out_fire) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    skid_to_main = 1'b1;
                    state_n      = ONE;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // Handshake flags are derived from the next state so they stay registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= (state_n != FULL);
            out_valid <= (state_n != EMPTY);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            skid_q   <= '0;
        end else begin
            if (load_main)
                out_data <= ext_res;
            else if (skid_to_main)
                out_data <= skid_q;
            if (load_skid)
                skid_q <= ext_res;
        end
    end

`ifdef IMM_EXTEND_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ext_count <= '0;
        else if (out_fire)
            ext_count <= ext_count + 32'd1;
    end
`endif

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate-extension unit for the MIPS decode→execute path. It succeeds the fixed 16→32 sign extender.
- Widths are generic.
- Four extension modes: sign, zero, upper/LUI, branch-offset.
- Results are registered behind a valid/ready handshake with a 2-entry skid buffer, giving full throughput under backpressure.
- Sits between the decoder's immediate field and the ALU B-operand mux.

Parameters:
- IN_W, 16, immediate input width; legal range 1 ≤ IN_W < OUT_W.
- OUT_W, 32, extended output width.
- BR_SHIFT, 2, left shift applied in BRANCH mode; requires IN_W+BR_SHIFT ≤ OUT_W.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream offers imm/mode this cycle.
- in_ready  output  1  block can accept; registered.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  ext_mode_t: 0 SIGN, 1 ZERO, 2 UPPER, 3 BRANCH.
- out_valid  output  1  out_data holds a valid result.
- out_ready  input  1  downstream consumes when high with out_valid.
- out_data  output  OUT_W  extended result.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, in_ready=1, both buffer entries cleared, state EMPTY.
- Arithmetic (width rules):
  - SIGN: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
  - ZERO: upper bits 0.
  - UPPER: in_imm placed at [OUT_W-1:OUT_W-IN_W], lower bits 0.
  - BRANCH: sign-extend to OUT_W, then shift left by BR_SHIFT, discarding the shifted-out MSBs.
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_data and out_valid must stay stable while out_valid && !out_ready.
- Latency: 1 cycle. A result accepted at edge N is visible on out_data after edge N.
- Storage: main register (drives outputs) plus skid register.
- State machine (ext_state_t):
  - EMPTY: in_fire → main loads, go ONE.
  - ONE:
    - in_fire && out_fire → main reloads, stay ONE.
    - in_fire && !out_fire → skid loads, go FULL.
    - !in_fire && out_fire → go EMPTY.
  - FULL: in_ready=0.
    - out_fire → skid moves to main, go ONE.
    - Otherwise hold.
- in_ready is registered: high in EMPTY and ONE, low only in FULL. Never combinationally dependent on out_ready.
- Ordering is strictly FIFO; no drops, no duplicates.
- Boundary conditions:
  - in_valid while FULL: ignored; upstream must hold.
  - Simultaneous in/out fire in ONE: sustains 1 result/cycle.
  - Reset mid-operation: all buffered results discarded immediately (asynchronous clear); first accept is possible on the first edge after reset deasserts.
- All 4 in_mode encodings are legal; no error path.

Optional Feature:
- Macro: IMM_EXTEND_STATS_EN.
- Defined: adds output port ext_count [31:0], incremented on every out_fire. It wraps 0xFFFFFFFF→0 and resets to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package imm_ext_pkg holds:
  - ext_mode_t enum (SIGN=2'd0, ZERO=2'd1, UPPER=2'd2, BRANCH=2'd3).
  - ext_state_t enum (EMPTY, ONE, FULL).
  - Default width constants IMM_IN_W=16, IMM_OUT_W=32.
- One sub-module, imm_ext_core: purely combinational (in_imm, in_mode) → OUT_W result, parametrised identically.
- imm_extend_pipe owns the handshake, skid buffer, FSM and optional counter.

Test Plan:
- SIGN 0x8000 → 0xFFFF8000; SIGN 0x7FFF → 0x00007FFF, each appearing 1 cycle after accept with out_ready=1.
- ZERO 0x8000 → 0x00008000; UPPER 0x1234 → 0x12340000; BRANCH 0xFFFF → 0xFFFFFFFC; BRANCH 0x0001 → 0x00000004.
- Streaming: 8 back-to-back inputs with out_ready held high → 8 outputs on consecutive cycles, in_ready never low.
- Backpressure: out_ready=0 while offering A, B, C →
  - A and B accepted, then in_ready=0 and C held.
  - Release out_ready → outputs A, B, C in order; out_data stable throughout the stall.
- Reset asserted asynchronously in FULL →
  - out_valid=0 and in_ready=1 without waiting for a clock edge.
  - The next input after reset emerges alone.
- With IMM_EXTEND_STATS_EN: 5 transfers → ext_count=5; preload near 0xFFFFFFFF via forced transfers to confirm wrap to 0.
